uart_tx: RTL



---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_tick_edge.sv | 23 ++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: baud defaults, frame width default and the
// transmitter state encoding. Imported by the tx datapath and usable by RX.
package uart_tx_pkg;

    // Baud generator defaults (tick toggles every BAUD_HALF_DEF clocks)
    localparam int CLK_HZ_DEF    = 50_000_000;
    localparam int BAUD_DEF      = 115_200;
    localparam int BAUD_HALF_DEF = CLK_HZ_DEF / (2 * BAUD_DEF);

    // Default number of data bits per frame
    localparam int DATA_W_DEF = 8;

    // Width of the shared bit/stop counter (covers DATA_W up to 8)
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_tick_edge.sv
// Rising-edge detector for the toggling baud tick. tick_d resets high so a
// tick that is already high when reset releases does not fire a strobe.
module tick_edge (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic bit_stb
);

    logic tick_d;

    // Delayed copy of tick for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_d <= 1'b1;
        end else begin
            tick_d <= tick;
        end
    end

    assign bit_stb = tick & ~tick_d;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames bytes into start/data/[parity]/stop bits, one bit
// per rising edge of the baud tick. Build option UART_PARITY_EN inserts a
// parity bit after the data bits.
//
// Handshake: a byte is taken in the cycle where tx_valid and tx_ready are both
// high; tx_ready stays low until the final stop bit completes, and tx_valid is
// ignored meanwhile. All line outputs are registered; state is exposed for
// debug.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_done,
    output tx_state_t         state
);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    // Reject unsupported parameter combinations at elaboration
    if (DATA_W < 5 || DATA_W > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx: illegal parameter combination");
    end

    logic              bit_stb;
    tx_state_t         state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              tx_n, ready_n, done_n;
`ifdef UART_PARITY_EN
    logic              par_bit, par_n;
`endif

    tick_edge u_tick_edge (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .bit_stb (bit_stb)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            tx       <= tx_n;
            tx_ready <= ready_n;
            tx_done  <= done_n;
`ifdef UART_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

    // Next-state and next-output logic; nothing moves without a bit strobe
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx;
        ready_n   = tx_ready;
        done_n    = 1'b0;
`ifdef UART_PARITY_EN
        par_n     = par_bit;
`endif
        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                if (tx_valid && tx_ready) begin
                    shift_n   = tx_data;
                    bit_cnt_n = '0;
                    ready_n   = 1'b0;
                    state_n   = ARM;
`ifdef UART_PARITY_EN
                    par_n     = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ARM: begin
                // A strobe in the accept cycle is seen while still in IDLE
                if (bit_stb) begin
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_stb) begin
                    tx_n    = shift[0];
                    shift_n = shift >> 1;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_stb) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        tx_n    = par_bit;
                        state_n = PARITY;
`else
                        tx_n      = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = STOP;
`endif
                    end else begin
                        tx_n    = shift[0];
                        shift_n = shift >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_stb) begin
                    tx_n      = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                // bit_cnt counts completed stop bits
                if (bit_stb) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_n    = 1'b1;
                        ready_n   = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule
